mf8_uart_rx: RTL and testbench
==============================

// Module: mf8_uart_rx
// PURPOSE
//  Hardware UART receiver on the mf8_core IO bus, complementing the bit-banged UART_TXD output.
//  Oversamples the asynchronous RXD line and assembles 8N1 frames, LSB first.
//  Holds received bytes for the core to read via IO_Rd.
//  Sits beside the TXD/SPI port logic in the MF8A18 top; IO_RData is ORed with the other IO read sources.
// PARAMETERS
//  CLK_DIV     16      CLK cycles per bit; even, >= 4
//  BASE_ADDR   3'b100  IO_Addr[5:3] value that selects this block
//  FIFO_DEPTH  4       receive FIFO entries, power of 2; used only with MF8_UART_RX_FIFO_EN
// PORTS
//  CLK        in   1  system clock
//  Reset_s_n  in   1  reset, asynchronous, active-low
//  UART_RXD   in   1  serial input, asynchronous, idle high
//  IO_Rd      in   1  core IO read strobe, one cycle
//  IO_Wr      in   1  core IO write strobe, one cycle
//  IO_Addr    in   6  IO address; [5:3]=BASE_ADDR selects, [0] selects register
//  IO_WData   in   8  IO write data
//  IO_RData   out  8  read data; combinational, 8'h00 unless IO_Rd and selected
// BEHAVIOUR
//  Registers: off 0 DATA (RO, read pops); off 1 STATUS: [0] RX_VALID, [1] OVERRUN, [2] FRAME_ERR, [7] synced RXD level, others 0.
//  STATUS write: bits [1]/[2] are write-1-to-clear; other bits ignored. DATA write is ignored.
//  Sync: 2-flop synchronizer, both flops reset to 1. prev flop (reset 1) detects a 1->0 falling edge.
//  E0: the edge at which sync stage 2 first holds 0 while in IDLE.
//  FSM states: IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
//   IDLE  -> START on falling edge; bit counter loaded so the sample occurs at E0+CLK_DIV/2.
//   START -> sample at E0+CLK_DIV/2. Line 0: go to DATA. Line 1: false start, go to IDLE with nothing recorded.
//   DATA  -> bit i (i=0..7) sampled at E0+CLK_DIV/2+(i+1)*CLK_DIV into the shift register, LSB first. Then STOP.
//   STOP  -> sample at E0+CLK_DIV/2+9*CLK_DIV.
//            Line 1: push byte, go to IDLE.
//            Line 0: set FRAME_ERR, discard byte, go to BREAK.
//   BREAK -> stay until synced line is 1, then IDLE. This avoids re-triggering on a held-low line.
//  Push: storage updates and RX_VALID is set at the stop-sample edge; visible the following cycle.
//  Pop: DATA read with IO_Rd returns the oldest byte that cycle; storage advances at that cycle's closing edge.
//  DATA read while empty returns 8'h00 and has no side effect.
//  Full + push (no same-cycle pop): new byte dropped, OVERRUN set, stored data unchanged.
//  Push + pop same cycle: both take effect; never sets OVERRUN; count unchanged when non-empty.
//  Flags are sticky until W1C or reset.
//  If a W1C clear and a set event occur in the same cycle, the set wins.
//  Reset (any time, including mid-frame): FSM IDLE, storage empty, all flags 0, sync/prev = 1, IO_RData = 0.
//  RXD held low through reset: produces one frame attempt on release, which yields FRAME_ERR, then BREAK.
// CONFIGURATION
//  MF8_UART_RX_FIFO_EN defined:
//   - Storage is a FIFO_DEPTH circular buffer (wr/rd pointers plus count); pointers wrap modulo FIFO_DEPTH.
//   - RX_VALID = (count != 0). Full means count == FIFO_DEPTH.
//  MF8_UART_RX_FIFO_EN undefined:
//   - Storage is a single holding register with a valid flag; full means valid == 1.
//   - FIFO_DEPTH is ignored.
// TESTING
//  1. CLK_DIV=16, send 8N1 0x55.
//     -> STATUS reads 0x81 from E0+152+1; DATA reads 0x55; next STATUS reads 0x80.
//  2. RXD low for 4 CLK only, then high.
//     -> FSM returns to IDLE at E0+8; STATUS stays 0x80; no push.
//  3. Send 0xA3 with stop bit 0.
//     -> STATUS[2]=1, [0]=0. FSM stays in BREAK until RXD=1.
//     Write STATUS 0x04 -> STATUS reads 0x80.
//  4. No FIFO: send 0x11 then 0x22, no reads.
//     -> STATUS 0x83, DATA 0x11. Then write 0x02 -> STATUS 0x80.
//  5. FIFO_EN, depth 4: send 0x01..0x05, no reads.
//     -> OVERRUN=1; reads return 0x01,0x02,0x03,0x04, then RX_VALID=0.
//     Also: pop coincident with a push -> no overrun.
//  6. Assert Reset_s_n=0 during data bit 3, release, send 0x7E.
//     -> no partial byte; only 0x7E received; flags 0.

Source files
------------

// File: rtl/mf8_uart_rx_if.sv
// mf8_core IO bus signals seen by the UART receiver.
// master = core side, slave = mf8_uart_rx side.
interface mf8_uart_rx_if;
    logic       IO_Rd;
    logic       IO_Wr;
    logic [5:0] IO_Addr;
    logic [7:0] IO_WData;
    logic [7:0] IO_RData;

    modport master (output IO_Rd, IO_Wr, IO_Addr, IO_WData, input IO_RData);
    modport slave  (input IO_Rd, IO_Wr, IO_Addr, IO_WData, output IO_RData);
endinterface

// File: rtl/mf8_uart_rx.sv
// mf8_uart_rx: oversampling 8N1 UART receiver with DATA/STATUS registers on the mf8_core IO bus.
// Define MF8_UART_RX_FIFO_EN for a FIFO_DEPTH-entry (power of 2, >= 2) receive FIFO; default is one holding register.
module mf8_uart_rx #(
    parameter int unsigned CLK_DIV    = 16,
    parameter logic [2:0]  BASE_ADDR  = 3'b100,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         CLK,
    input  logic         Reset_s_n,
    input  logic         UART_RXD,
    mf8_uart_rx_if.slave io
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    // First sample lands CLK_DIV/2 edges after E0; the IDLE->START edge is already E0+1.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 2);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          sync1, sync2, prev;
    logic          push, fe_set;
    logic          overrun, frame_err;
    logic          empty, full, pop, do_wr;
    logic [7:0]    head;
    logic          sel, rd_data, rd_stat, wr_stat, tick;

    assign sel     = (io.IO_Addr[5:3] == BASE_ADDR);
    assign rd_data = sel && io.IO_Rd && !io.IO_Addr[0];
    assign rd_stat = sel && io.IO_Rd &&  io.IO_Addr[0];
    assign wr_stat = sel && io.IO_Wr &&  io.IO_Addr[0];
    assign pop     = rd_data && !empty;
    assign do_wr   = push && (!full || pop);
    assign tick    = (cnt == '0);

    always_ff @(posedge CLK or negedge Reset_s_n) begin
        if (!Reset_s_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            prev    <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            sync1   <= UART_RXD;
            sync2   <= sync1;
            prev    <= sync2;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        push      = 1'b0;
        fe_set    = 1'b0;
        if ((state == S_START || state == S_DATA || state == S_STOP) && !tick)
            cnt_n = cnt - CW'(1);
        unique case (state)
            S_IDLE: begin
                if (prev && !sync2) begin
                    state_n = S_START;
                    cnt_n   = HALF_LOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!sync2) begin
                        state_n   = S_DATA;
                        cnt_n     = FULL_LOAD;
                        bit_cnt_n = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_n = {sync2, shreg[7:1]};
                    cnt_n   = FULL_LOAD;
                    if (bit_cnt == 3'd7) state_n = S_STOP;
                    else                 bit_cnt_n = bit_cnt + 3'd1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (sync2) begin
                        push    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (sync2) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Sticky flags: a set event in the same cycle as a W1C clear wins.
    always_ff @(posedge CLK or negedge Reset_s_n) begin
        if (!Reset_s_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push && full && !pop)               overrun <= 1'b1;
            else if (wr_stat && io.IO_WData[1])     overrun <= 1'b0;
            if (fe_set)                             frame_err <= 1'b1;
            else if (wr_stat && io.IO_WData[2])     frame_err <= 1'b0;
        end
    end

`ifdef MF8_UART_RX_FIFO_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    assign empty = (count == '0);
    assign full  = (count == (PW + 1)'(FIFO_DEPTH));
    assign head  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_wr) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge CLK or negedge Reset_s_n) begin
        if (!Reset_s_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (do_wr && !pop)      count <= count + (PW + 1)'(1);
            else if (pop && !do_wr) count <= count - (PW + 1)'(1);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{io.IO_WData[7:3], io.IO_WData[0], io.IO_Addr[2:1]};
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    assign empty = !hold_valid;
    assign full  = hold_valid;
    assign head  = hold_data;

    always_ff @(posedge CLK or negedge Reset_s_n) begin
        if (!Reset_s_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (do_wr) begin
                hold_data  <= shreg;
                hold_valid <= 1'b1;
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{io.IO_WData[7:3], io.IO_WData[0], io.IO_Addr[2:1], (FIFO_DEPTH != 0)};
`endif

    always_comb begin
        io.IO_RData = '0;
        if (Reset_s_n) begin
            if (rd_data && !empty) io.IO_RData = head;
            else if (rd_stat)      io.IO_RData = {sync2, 4'b0000, frame_err, overrun, !empty};
        end
    end
endmodule

// File: tb/tb_mf8_uart_rx.sv
// Self-checking bench for mf8_uart_rx: random 8N1 frames against a queue-based receiver model.
// Define MF8_UART_RX_FIFO_EN here too when building the FIFO variant.
module tb_mf8_uart_rx;
    localparam int unsigned CLK_DIV = 16;
`ifdef MF8_UART_RX_FIFO_EN
    localparam int unsigned DEPTH = 4;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [5:0] A_DATA = 6'b100_000;
    localparam logic [5:0] A_STAT = 6'b100_001;

    logic CLK = 1'b0;
    logic Reset_s_n = 1'b0;
    logic UART_RXD = 1'b1;
    mf8_uart_rx_if bus ();

    mf8_uart_rx #(.CLK_DIV(CLK_DIV), .BASE_ADDR(3'b100), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .Reset_s_n(Reset_s_n), .UART_RXD(UART_RXD), .io(bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: received bytes in arrival order, plus sticky flags.
    logic [7:0] q[$];
    logic m_ovr = 1'b0;
    logic m_fe = 1'b0;

    function automatic void m_reset();
        q.delete();
        m_ovr = 1'b0;
        m_fe = 1'b0;
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (q.size() >= DEPTH) m_ovr = 1'b1;
        else q.push_back(b);
    endfunction

    function automatic logic [7:0] m_pop();
        if (q.size() == 0) return 8'h00;
        return q.pop_front();
    endfunction

    function automatic logic [7:0] m_status(input logic line);
        return {line, 4'b0000, m_fe, m_ovr, (q.size() != 0)};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic io_read(input logic [5:0] a, output logic [7:0] d);
        bus.IO_Rd = 1'b1;
        bus.IO_Addr = a;
        #1 d = bus.IO_RData;
        @(posedge CLK);
        #1 bus.IO_Rd = 1'b0;
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        bus.IO_Wr = 1'b1;
        bus.IO_Addr = a;
        bus.IO_WData = d;
        @(posedge CLK);
        #1 bus.IO_Wr = 1'b0;
    endtask

    // mode 0: plain; 1: STATUS read in the cycle before and after the push edge; 2: DATA pop in the push cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int mode,
                              output logic [7:0] pre, output logic [7:0] post);
        pre = '0;
        post = '0;
        UART_RXD = 1'b0;
        repeat (CLK_DIV) @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            #1 UART_RXD = b[i];
            repeat (CLK_DIV) @(posedge CLK);
        end
        #1 UART_RXD = stop;
        if (mode == 1) begin
            repeat (CLK_DIV / 2 + 1) @(posedge CLK);
            #1 io_read(A_STAT, pre);
            io_read(A_STAT, post);
            idle(CLK_DIV / 2 - 3);
        end else if (mode == 2) begin
            repeat (CLK_DIV / 2 + 1) @(posedge CLK);
            #1 io_read(A_DATA, pre);
            idle(CLK_DIV / 2 - 2);
        end else begin
            idle(CLK_DIV);
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        bus.IO_Rd = 1'b0; bus.IO_Wr = 1'b0; bus.IO_Addr = '0; bus.IO_WData = '0;
        Reset_s_n = 1'b0;
        idle(3);
        io_read(A_STAT, got);
        checks++;
        if (got !== 8'h00) begin errors++; $display("FAIL reset_rdata got %02h exp 00", got); end
        Reset_s_n = 1'b1;
        m_reset();
        idle(4);
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL reset_status got %02h exp %02h", got, m_status(1'b1)); end
        io_read(A_DATA, got);
        checks++;
        if (got !== 8'h00) begin errors++; $display("FAIL empty_data got %02h exp 00", got); end
    endtask

    task automatic test_single_byte();
        logic [7:0] pre, post, got, b, exp;
        send_frame(8'h55, 1'b1, 1, pre, post);
        checks++;
        if (pre !== 8'h80) begin errors++; $display("FAIL push_timing_before got %02h exp 80", pre); end
        m_push(8'h55);
        checks++;
        if (post !== m_status(1'b1)) begin errors++; $display("FAIL push_timing_after got %02h exp %02h", post, m_status(1'b1)); end
        io_read(A_DATA, got);
        exp = m_pop();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL data_55 got %02h exp %02h", got, exp); end
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL status_after_pop got %02h exp %02h", got, m_status(1'b1)); end
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            idle($urandom_range(0, 20));
            send_frame(b, 1'b1, 0, pre, post);
            m_push(b);
            idle($urandom_range(0, 5));
            io_read(A_DATA, got);
            exp = m_pop();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random_byte got %02h exp %02h", got, exp); end
        end
    endtask

    task automatic test_false_start();
        logic [7:0] got, pre, post, b, exp;
        UART_RXD = 1'b0;
        idle(4);
        UART_RXD = 1'b1;
        idle(3 * CLK_DIV);
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL false_start_status got %02h exp %02h", got, m_status(1'b1)); end
        b = 8'($urandom);
        send_frame(b, 1'b1, 0, pre, post);
        m_push(b);
        io_read(A_DATA, got);
        exp = m_pop();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL after_false_start got %02h exp %02h", got, exp); end
    endtask

    task automatic test_frame_error();
        logic [7:0] got, pre, post;
        send_frame(8'hA3, 1'b0, 0, pre, post);
        m_fe = 1'b1;
        idle(2);
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b0)) begin errors++; $display("FAIL frame_err_status got %02h exp %02h", got, m_status(1'b0)); end
        io_write(A_STAT, 8'h04);
        m_fe = 1'b0;
        idle(12 * CLK_DIV);
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b0)) begin errors++; $display("FAIL break_no_retrigger got %02h exp %02h", got, m_status(1'b0)); end
        UART_RXD = 1'b1;
        idle(4);
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL break_release got %02h exp %02h", got, m_status(1'b1)); end
    endtask

    task automatic test_overrun();
        logic [7:0] got, pre, post, b, exp;
        for (int n = 0; n < DEPTH + 1; n++) begin
            b = 8'($urandom);
            idle($urandom_range(0, 20));
            send_frame(b, 1'b1, 0, pre, post);
            m_push(b);
        end
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL overrun_status got %02h exp %02h", got, m_status(1'b1)); end
        io_write(A_DATA, 8'($urandom));
        io_write(A_STAT, 8'hF9);
        while (q.size() != 0) begin
            io_read(A_DATA, got);
            exp = m_pop();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL overrun_drain got %02h exp %02h", got, exp); end
        end
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL overrun_sticky got %02h exp %02h", got, m_status(1'b1)); end
        io_write(A_STAT, 8'h02);
        m_ovr = 1'b0;
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL overrun_clear got %02h exp %02h", got, m_status(1'b1)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, pre, post, b, exp;
        for (int n = 0; n < DEPTH; n++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 0, pre, post);
            m_push(b);
        end
        b = 8'($urandom);
        send_frame(b, 1'b1, 2, pre, post);
        exp = m_pop();
        m_push(b);
        checks++;
        if (pre !== exp) begin errors++; $display("FAIL coincident_pop got %02h exp %02h", pre, exp); end
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL coincident_status got %02h exp %02h", got, m_status(1'b1)); end
        while (q.size() != 0) begin
            io_read(A_DATA, got);
            exp = m_pop();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL coincident_drain got %02h exp %02h", got, exp); end
        end
        io_read(A_DATA, got);
        checks++;
        if (got !== 8'h00) begin errors++; $display("FAIL drained_data got %02h exp 00", got); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got, pre, post, b, exp;
        b = 8'($urandom);
        send_frame(b, 1'b1, 0, pre, post);
        m_push(b);
        b = 8'($urandom);
        UART_RXD = 1'b0;
        repeat (CLK_DIV) @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            #1 UART_RXD = b[i];
            repeat (CLK_DIV) @(posedge CLK);
        end
        #1 UART_RXD = b[3];
        idle(CLK_DIV / 2 - 2);
        Reset_s_n = 1'b0;
        UART_RXD = 1'b1;
        m_reset();
        idle(3);
        Reset_s_n = 1'b1;
        idle(2 * CLK_DIV);
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL midframe_reset_status got %02h exp %02h", got, m_status(1'b1)); end
        send_frame(8'h7E, 1'b1, 0, pre, post);
        m_push(8'h7E);
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL after_reset_status got %02h exp %02h", got, m_status(1'b1)); end
        io_read(A_DATA, got);
        exp = m_pop();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL after_reset_data got %02h exp %02h", got, exp); end
    endtask

    task automatic test_low_through_reset();
        logic [7:0] got;
        UART_RXD = 1'b0;
        Reset_s_n = 1'b0;
        m_reset();
        idle(3);
        Reset_s_n = 1'b1;
        idle(11 * CLK_DIV);
        m_fe = 1'b1;
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b0)) begin errors++; $display("FAIL low_reset_fe got %02h exp %02h", got, m_status(1'b0)); end
        UART_RXD = 1'b1;
        idle(4);
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL low_reset_release got %02h exp %02h", got, m_status(1'b1)); end
        io_write(A_STAT, 8'h04);
        m_fe = 1'b0;
        io_read(A_STAT, got);
        checks++;
        if (got !== m_status(1'b1)) begin errors++; $display("FAIL low_reset_clear got %02h exp %02h", got, m_status(1'b1)); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_low_through_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
